csi2_delay_ctrl: RTL and testbench

//  Sequences reprogramming of per-lane input delay taps in the CSI-2 RX PHY. On a DELAY_ACT_CR

---
 rtl/csi2_delay_ctrl.sv | 151 +++++++++++++++
 tb/tb_csi2_delay_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_delay_ctrl.sv
// csi2_delay_ctrl: sequences reprogramming of the CSI-2 RX per-lane input delay taps.
// On an activate strobe it snapshots the lane taps, gates the PHY off, loads each
// delay line in turn, waits for settling, then restores the PHY enable.
// Optional feature macro: CSI2_DELAY_CLEAR_STAT_EN (clear_stat_o pulses with done_o).
module csi2_delay_ctrl #(
    parameter int unsigned LANES         = 2,
    parameter int unsigned DELAY_W       = 5,
    parameter int unsigned DRAIN_CYCLES  = 8,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       phy_enable_i,
    input  logic [LANES*DELAY_W-1:0]   lane_delay_i,
    input  logic                       delay_act_i,
    input  logic                       idelay_rdy_i,
    output logic [LANES*DELAY_W-1:0]   idelay_value_o,
    output logic [LANES-1:0]           idelay_load_o,
    output logic                       phy_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       clear_stat_o
);

    localparam int unsigned CntMax = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES
                                                                    : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned LaneW  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StSetup,
        StLoad,
        StSettle,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [LaneW-1:0]            lane_q, lane_d;
    logic [LANES*DELAY_W-1:0]    snap_q, snap_d;
    logic [LANES*DELAY_W-1:0]    value_q, value_d;
    logic                        pend_q, pend_d;
    logic                        phy_en_q;

    // State, snapshot, tap values and the 1-cycle-lagged PHY enable used while idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lane_q   <= '0;
            snap_q   <= '0;
            value_q  <= '0;
            pend_q   <= 1'b0;
            phy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            snap_q   <= snap_d;
            value_q  <= value_d;
            pend_q   <= pend_d;
            phy_en_q <= phy_enable_i;
        end
    end

    // Next-state and output decode for the reprogramming sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lane_d        = lane_q;
        snap_d        = snap_q;
        value_d       = value_q;
        pend_d        = pend_q;
        idelay_load_o = '0;
        phy_en_o      = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        // Any strobe outside IDLE (including DONE) collapses into one pending request.
        if (delay_act_i && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                phy_en_o = phy_en_q;
                if ((delay_act_i || pend_q) && idelay_rdy_i) begin
                    state_d = StDrain;
                    snap_d  = lane_delay_i;
                    pend_d  = 1'b0;
                    cnt_d   = CntW'(DRAIN_CYCLES - 1);
                end else if (delay_act_i) begin
                    pend_d = 1'b1;
                end
            end
            StDrain: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StSetup;
                    lane_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSetup: begin
                busy_o = 1'b1;
                value_d[lane_q*DELAY_W +: DELAY_W] = snap_q[lane_q*DELAY_W +: DELAY_W];
                state_d = StLoad;
            end
            StLoad: begin
                busy_o                = 1'b1;
                idelay_load_o[lane_q] = 1'b1;
                if (lane_q == LaneW'(LANES - 1)) begin
                    state_d = StSettle;
                    cnt_d   = CntW'(SETTLE_CYCLES - 1);
                end else begin
                    lane_d  = lane_q + 1'b1;
                    state_d = StSetup;
                end
            end
            StSettle: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                done_o   = 1'b1;
                phy_en_o = phy_enable_i;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign idelay_value_o = value_q;

`ifdef CSI2_DELAY_CLEAR_STAT_EN
    // Restart error/line/pixel statistics under the new taps.
    assign clear_stat_o = done_o;
`else
    assign clear_stat_o = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_delay_ctrl.sv
// Self-checking bench for csi2_delay_ctrl: directed scenarios followed by random
// strobes/ready/taps, all compared against a timeline-based reference model.
module tb_csi2_delay_ctrl;

    localparam int unsigned L  = 2;
    localparam int unsigned DW = 5;
    localparam int unsigned D  = 8;
    localparam int unsigned S  = 16;
    // Offsets from the first DRAIN cycle: lane k loads at LoadOff + 2k, done at DoneOff.
    localparam int LoadOff = D + 1;
    localparam int DoneOff = D + 2 * L + S;

    logic              clk;
    logic              rst_n;
    logic              phy_enable;
    logic [L*DW-1:0]   lane_delay;
    logic              act;
    logic              rdy;
    logic [L*DW-1:0]   idelay_value;
    logic [L-1:0]      idelay_load;
    logic              phy_en;
    logic              busy;
    logic              done;
    logic              clear_stat;

    csi2_delay_ctrl #(
        .LANES        (L),
        .DELAY_W      (DW),
        .DRAIN_CYCLES (D),
        .SETTLE_CYCLES(S)
    ) u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .phy_enable_i  (phy_enable),
        .lane_delay_i  (lane_delay),
        .delay_act_i   (act),
        .idelay_rdy_i  (rdy),
        .idelay_value_o(idelay_value),
        .idelay_load_o (idelay_load),
        .phy_en_o      (phy_en),
        .busy_o        (busy),
        .done_o        (done),
        .clear_stat_o  (clear_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    // Reference model: a sequence is a timeline starting at m_start.
    int              cyc = 0;
    bit              m_act = 0;
    int              m_start = 0;
    bit              m_pend = 0;
    bit              m_phy = 0;
    logic [DW-1:0]   m_snap [L];
    logic [DW-1:0]   m_val  [L];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = 0;
        m_pend = 0;
        m_phy  = 0;
        for (int k = 0; k < L; k++) begin
            m_snap[k] = '0;
            m_val[k]  = '0;
        end
    endtask

    // One clock cycle: compare at negedge, advance model, return at posedge+1.
    task automatic step();
        logic [L-1:0]    e_load;
        logic            e_done;
        logic            e_busy;
        logic            e_phy;
        logic [L*DW-1:0] e_val;
        int              off;
        @(negedge clk);
        e_load = '0;
        e_done = 0;
        e_busy = 0;
        e_phy  = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_act) begin
            off = cyc - m_start;
            for (int k = 0; k < L; k++) begin
                if (off == LoadOff + 2 * k) begin
                    m_val[k]  = m_snap[k];
                    e_load[k] = 1'b1;
                end
            end
            e_done = (off == DoneOff);
            e_busy = !e_done;
            e_phy  = e_done ? phy_enable : 1'b0;
        end else begin
            e_phy = m_phy;
        end
        for (int k = 0; k < L; k++) e_val[k*DW +: DW] = m_val[k];

        check_eq("load", 32'(idelay_load), 32'(e_load));
        check_eq("value", 32'(idelay_value), 32'(e_val));
        check_eq("phy_en", 32'(phy_en), 32'(e_phy));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("done", 32'(done), 32'(e_done));
`ifdef CSI2_DELAY_CLEAR_STAT_EN
        check_eq("clear_stat", 32'(clear_stat), 32'(e_done));
`else
        check_eq("clear_stat", 32'(clear_stat), 32'd0);
`endif
        if (done) n_done++;

        if (rst_n) begin
            if (m_act) begin
                if (act) m_pend = 1;
                if (e_done) m_act = 0;
            end else if ((act || m_pend) && rdy) begin
                m_act   = 1;
                m_start = cyc + 1;
                m_pend  = 0;
                for (int k = 0; k < L; k++) m_snap[k] = lane_delay[k*DW +: DW];
            end else if (act) begin
                m_pend = 1;
            end
            m_phy = phy_enable;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe();
        act = 1'b1;
        step();
        act = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        phy_enable = 1'b1;
        rdy        = 1'b1;
        act        = 1'b0;
        lane_delay = '0;
        model_reset();
        #1;

        // Reset: phy_en 0 during reset, 1 one cycle after release.
        steps(3);
        rst_n = 1'b1;
        steps(3);

        // Taps lane1=7, lane0=19: loads at cycles 10/12, done at 29.
        lane_delay = {5'd7, 5'd19};
        n_done = 0;
        strobe();
        steps(35);
        check_eq("t2_done_count", 32'(n_done), 32'd1);
        check_eq("t2_final_taps", 32'(idelay_value), 32'({5'd7, 5'd19}));

        // Strobe while not ready, ready 5 cycles later.
        rdy = 1'b0;
        n_done = 0;
        strobe();
        steps(4);
        rdy = 1'b1;
        steps(35);
        check_eq("t3_done_count", 32'(n_done), 32'd1);

        // Three strobes while busy collapse into one extra sequence with fresh taps.
        lane_delay = {5'd11, 5'd22};
        n_done = 0;
        strobe();
        steps(5);
        lane_delay = {5'd3, 5'd3};
        for (int i = 0; i < 3; i++) begin
            strobe();
            steps(2);
        end
        steps(70);
        check_eq("t4_done_count", 32'(n_done), 32'd2);
        check_eq("t4_final_taps", 32'(idelay_value), 32'({5'd3, 5'd3}));

        // Reset during SETTLE: outputs drop asynchronously, no done afterwards.
        lane_delay = {5'd9, 5'd30};
        n_done = 0;
        strobe();
        steps(20);
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_load", 32'(idelay_load), 32'd0);
        check_eq("t5_async_value", 32'(idelay_value), 32'd0);
        check_eq("t5_async_phy", 32'(phy_en), 32'd0);
        check_eq("t5_async_busy", 32'(busy), 32'd0);
        check_eq("t5_async_done", 32'(done), 32'd0);
        steps(2);
        rst_n = 1'b1;
        steps(40);
        check_eq("t5_done_count", 32'(n_done), 32'd0);

        // Random phase.
        for (int i = 0; i < 2500; i++) begin
            act = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 40) == 0) phy_enable = ~phy_enable;
            lane_delay = L*DW'($urandom);
            step();
        end
        act = 1'b0;
        rdy = 1'b1;
        steps(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
